tdm_mux8_tx: RTL and testbench



---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_slot_timer.sv | 38 +++
 rtl/tdm_mux8_tx.sv | 78 +++++++
 tb/tb_tdm_mux8_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants for the TDM transmitter: lane count, select width, FSM encoding
// and the sel bit-reversal helper that matches the demux's {sel[0],sel[1],sel[2]} decode.
package tdm_pkg;
    localparam int LANES = 8;
    localparam int SEL_W = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    function automatic logic [SEL_W-1:0] bit_rev(input logic [SEL_W-1:0] v);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < SEL_W; i++) begin
            r[i] = v[SEL_W-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/tdm_slot_timer.sv
// Slot timing: hold counter and lane index; slot_end marks the last cycle of a slot.
// Combinational strobes, registered counters; start has priority over run.
module tdm_slot_timer
    import tdm_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    output logic             slot_end,
    output logic             frame_end,
    output logic [SEL_W-1:0] idx
);
    logic [7:0] hold;

    assign slot_end  = (hold == 8'(HOLD_CYCLES - 1));
    assign frame_end = slot_end && (idx == SEL_W'(LANES - 1));

    // With HOLD_CYCLES=1 slot_end is constant, so hold never leaves zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            idx  <= '0;
        end else if (start) begin
            hold <= '0;
            idx  <= '0;
        end else if (run) begin
            if (slot_end) begin
                hold <= '0;
                idx  <= frame_end ? '0 : idx + SEL_W'(1);
            end else begin
                hold <= hold + 8'd1;
            end
        end
    end
endmodule

// File: rtl/tdm_mux8_tx.sv
// Scans an accepted 8-bit word onto the demux D/sel/EN interface, one lane per slot; first slot 1 cycle after accept.
// in_ready only in IDLE or the last cycle of slot 7, so back-to-back frames run without an EN gap.
module tdm_mux8_tx
    import tdm_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             D,
    output logic [SEL_W-1:0] sel,
    output logic             EN,
    output logic             busy,
    output logic             frame_done
);
    logic [0:0]       state;
    logic [LANES-1:0] word;
    logic             slot_end;
    logic             frame_end;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] next_idx;
    logic             scanning;
    logic             last;
    logic             accept;

    assign scanning = (state == ST_SCAN);
    assign last     = scanning && frame_end;
    assign in_ready = (state == ST_IDLE) || last;
    assign accept   = in_valid && in_ready;
    assign next_idx = idx + SEL_W'(1);

    tdm_slot_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .run       (scanning),
        .slot_end  (slot_end),
        .frame_end (frame_end),
        .idx       (idx)
    );

    // Outputs are loaded one edge ahead with the values of the slot about to start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            word       <= '0;
            D          <= 1'b0;
            sel        <= '0;
            EN         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last;
            if (accept) begin
                state <= ST_SCAN;
                word  <= in_data;
                D     <= in_data[0];
                sel   <= '0;
                EN    <= 1'b1;
                busy  <= 1'b1;
            end else if (last) begin
                state <= ST_IDLE;
                D     <= 1'b0;
                sel   <= '0;
                EN    <= 1'b0;
                busy  <= 1'b0;
            end else if (scanning && slot_end) begin
                D   <= word[next_idx];
                sel <= bit_rev(next_idx);
            end
        end
    end
endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Bench for tdm_mux8_tx: two instances (HOLD_CYCLES 1 and 3) against a per-cycle reference
// derived from lane = cycle / HOLD_CYCLES, with a behavioural 1-to-8 demux on the outputs.
module tb_tdm_mux8_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] a_data = '0, b_data = '0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic       a_ready, b_ready, a_D, b_D, a_EN, b_EN, a_busy, b_busy, a_fd, b_fd;
    logic [2:0] a_sel, b_sel;

    logic       bsel = 1'b0;
    logic       o_ready, o_D, o_EN, o_busy, o_fd;
    logic [2:0] o_sel;
    logic [7:0] o_y;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tdm_mux8_tx #(.HOLD_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .D(a_D), .sel(a_sel), .EN(a_EN), .busy(a_busy), .frame_done(a_fd)
    );

    tdm_mux8_tx #(.HOLD_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .D(b_D), .sel(b_sel), .EN(b_EN), .busy(b_busy), .frame_done(b_fd)
    );

    // Observed view of the instance under test, plus the demux that decodes {sel[0],sel[1],sel[2]}.
    always_comb begin
        o_ready = bsel ? b_ready : a_ready;
        o_D     = bsel ? b_D     : a_D;
        o_sel   = bsel ? b_sel   : a_sel;
        o_EN    = bsel ? b_EN    : a_EN;
        o_busy  = bsel ? b_busy  : a_busy;
        o_fd    = bsel ? b_fd    : a_fd;
        o_y     = '0;
        if (o_EN) o_y[{o_sel[0], o_sel[1], o_sel[2]}] = o_D;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic b, input logic v, input logic [7:0] d);
        if (b) begin
            b_valid = v;
            b_data  = d;
        end else begin
            a_valid = v;
            a_data  = d;
        end
    endtask

    task automatic start(input logic b, input logic [7:0] w);
        bsel = b;
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        drv(b, 1'b1, w);
        tick();
    endtask

    task automatic check_idle(input logic b, input logic fd);
        bsel = b;
        chk("idle_fd", 32'(o_fd), 32'(fd));
        chk("idle_en", 32'(o_EN), 32'd0);
        chk("idle_d", 32'(o_D), 32'd0);
        chk("idle_sel", 32'(o_sel), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("idle_ready", 32'(o_ready), 32'd1);
    endtask

    // Called one cycle after accept; drives mid-frame noise and the optional next word.
    task automatic check_frame(input logic b, input logic [7:0] w, input int h,
                               input logic fd_first, input logic nv, input logic [7:0] nd);
        bsel = b;
        for (int k = 0; k < 8 * h; k++) begin
            int         lane;
            logic [2:0] l3;
            lane = k / h;
            l3   = 3'(lane);
            chk("en", 32'(o_EN), 32'd1);
            chk("d", 32'(o_D), 32'(w[lane]));
            chk("sel", 32'(o_sel), 32'({l3[0], l3[1], l3[2]}));
            chk("busy", 32'(o_busy), 32'd1);
            chk("frame_done", 32'(o_fd), 32'((k == 0) && fd_first));
            chk("in_ready", 32'(o_ready), 32'(k == 8 * h - 1));
            chk("demux_y", 32'(o_y), w[lane] ? (32'd1 << lane) : 32'd0);
            if (k == 8 * h - 1) drv(b, nv, nd);
            else drv(b, ($urandom_range(0, 2) == 0), 8'($urandom));
            tick();
        end
        drv(b, 1'b0, 8'($urandom));
    endtask

    initial begin
        logic       chained;
        logic       nchain;
        logic [7:0] w;
        logic [7:0] nw;
        int         off;

        // Reset state, both instances
        #12;
        check_idle(1'b0, 1'b0);
        check_idle(1'b1, 1'b0);
        rst = 1'b0;
        tick();

        // Directed pattern A5, one cycle per slot
        start(1'b0, 8'hA5);
        check_frame(1'b0, 8'hA5, 1, 1'b0, 1'b0, 8'h00);
        check_idle(1'b0, 1'b1);
        tick();
        check_idle(1'b0, 1'b0);

        // All 256 words in a shuffled order, randomly chained back-to-back
        off = int'($urandom_range(0, 255));
        chained = 1'b0;
        for (int i = 0; i < 256; i++) begin
            w  = 8'((i * 37 + off) & 255);
            nw = 8'(((i + 1) * 37 + off) & 255);
            if (!chained) start(1'b0, w);
            nchain = (i < 255) && ($urandom_range(0, 1) == 1);
            check_frame(1'b0, w, 1, chained, nchain, nw);
            if (!nchain) begin
                check_idle(1'b0, 1'b1);
                tick();
            end
            chained = nchain;
        end

        // Explicit back-to-back FF then 00
        start(1'b0, 8'hFF);
        check_frame(1'b0, 8'hFF, 1, 1'b0, 1'b1, 8'h00);
        check_frame(1'b0, 8'h00, 1, 1'b1, 1'b0, 8'h00);
        check_idle(1'b0, 1'b1);
        tick();

        // Three-cycle slots
        start(1'b1, 8'h01);
        check_frame(1'b1, 8'h01, 3, 1'b0, 1'b0, 8'h00);
        check_idle(1'b1, 1'b1);
        tick();
        w = 8'($urandom);
        nw = 8'($urandom);
        start(1'b1, w);
        check_frame(1'b1, w, 3, 1'b0, 1'b1, nw);
        check_frame(1'b1, nw, 3, 1'b1, 1'b0, 8'h00);
        check_idle(1'b1, 1'b1);
        tick();

        // Asynchronous reset during slot 4
        start(1'b0, 8'hFF);
        drv(1'b0, 1'b0, 8'h00);
        repeat (4) tick();
        chk("pre_reset_d", 32'(a_D), 32'd1);
        chk("pre_reset_sel", 32'(a_sel), 32'b001);
        rst = 1'b1;
        #1;
        check_idle(1'b0, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        start(1'b0, 8'h80);
        check_frame(1'b0, 8'h80, 1, 1'b0, 1'b0, 8'h00);
        check_idle(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
